// File: rtl/rf_pkg.sv
// Shared register-file writeback types and widths.
// Used by rf_wb_fifo and rf_wr_arbiter.
package rf_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   // One register-file write request: valid, destination and payload.
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // x0 is hard-wired to zero, so a write to it is never performed.
   function automatic logic rd_writable(input logic [REG_ADDR_W-1:0] rd);
      return rd != '0;
   endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Result buffer for the multi-cycle unit.
// Holds pending register writes in arrival order. Each entry carries a kill
// bit that a newer pipeline write to the same rd can set, so the stale value
// drains out without touching the register file.
// Optional macro RF_FWD_EN exposes the entry contents for forwarding lookups.
module rf_wb_fifo
   import rf_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [REG_ADDR_W-1:0] push_rd,
   input  logic [XLEN-1:0]       push_data,
   input  logic                  pop,
   input  logic                  kill_en,
   input  logic [REG_ADDR_W-1:0] kill_rd,
   output logic                  empty,
   output logic                  full,
   output logic [REG_ADDR_W-1:0] head_rd,
   output logic [XLEN-1:0]       head_data,
   output logic                  head_kill
`ifdef RF_FWD_EN
   ,
   output logic [DEPTH-1:0]            ent_live,
   output logic [DEPTH*REG_ADDR_W-1:0] ent_rd,
   output logic [DEPTH*XLEN-1:0]       ent_data,
   output logic [$clog2(DEPTH)-1:0]    head_ptr
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [REG_ADDR_W-1:0] rd_mem_q   [DEPTH];
   logic [REG_ADDR_W-1:0] rd_mem_d   [DEPTH];
   logic [XLEN-1:0]       data_mem_q [DEPTH];
   logic [XLEN-1:0]       data_mem_d [DEPTH];
   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [DEPTH-1:0]      kill_q, kill_d;
   logic [DEPTH-1:0]      rd_match;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  push_ok;
   logic                  pop_ok;

   // Status flags and head view; push/pop are ignored when they would overflow or underflow.
   always_comb begin
      empty     = (count_q == '0);
      full      = (count_q == CNT_W'(DEPTH));
      push_ok   = push & ~full;
      pop_ok    = pop & ~empty;
      head_rd   = rd_mem_q[rd_ptr_q];
      head_data = data_mem_q[rd_ptr_q];
      head_kill = kill_q[rd_ptr_q];
   end

   // Which live entries target the register the pipeline is writing right now.
   always_comb begin
      rd_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rd_match[i] = valid_q[i] & (rd_mem_q[i] == kill_rd);
      end
   end

   // Next state: kill matching entries, then pop the head, then append the new entry.
   always_comb begin
      rd_mem_d   = rd_mem_q;
      data_mem_d = data_mem_q;
      valid_d    = valid_q;
      kill_d     = kill_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (kill_en) begin
         kill_d = kill_q | rd_match;
      end

      if (pop_ok) begin
         valid_d[rd_ptr_q] = 1'b0;
         kill_d[rd_ptr_q]  = 1'b0;
         rd_ptr_d          = rd_ptr_q + 1'b1;
      end

      // The slot being written is free, so its kill bit starts clear: this result is newest.
      if (push_ok) begin
         rd_mem_d[wr_ptr_q]   = push_rd;
         data_mem_d[wr_ptr_q] = push_data;
         valid_d[wr_ptr_q]    = 1'b1;
         kill_d[wr_ptr_q]     = 1'b0;
         wr_ptr_d             = wr_ptr_q + 1'b1;
      end

      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers; reset discards every buffered entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_mem_q[i]   <= '0;
            data_mem_q[i] <= '0;
         end
         valid_q  <= '0;
         kill_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_mem_q[i]   <= rd_mem_d[i];
            data_mem_q[i] <= data_mem_d[i];
         end
         valid_q  <= valid_d;
         kill_q   <= kill_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

`ifdef RF_FWD_EN
   // Flattened entry view for the forwarding lookup in the arbiter.
   always_comb begin
      ent_live = valid_q & ~kill_q;
      ent_rd   = '0;
      ent_data = '0;
      head_ptr = rd_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         ent_rd[i*REG_ADDR_W +: REG_ADDR_W] = rd_mem_q[i];
         ent_data[i*XLEN +: XLEN]           = data_mem_q[i];
      end
   end
`endif

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter.
// The pipeline writeback slot always wins the single write port; results from
// the multi-cycle unit wait in rf_wb_fifo and drain on idle cycles. A starve
// counter asks the pipeline to stall when the buffer has been denied too long.
// Optional macro RF_FWD_EN adds two read-forwarding lookups over pending results.
module rf_wr_arbiter
   import rf_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  mdu_valid,
   input  logic [REG_ADDR_W-1:0] mdu_rd,
   input  logic [XLEN-1:0]       mdu_data,
   output logic                  mdu_ready,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  stall_req
`ifdef RF_FWD_EN
   ,
   input  logic [REG_ADDR_W-1:0] q_rs1,
   input  logic [REG_ADDR_W-1:0] q_rs2,
   output logic                  q_hit1,
   output logic                  q_hit2,
   output logic [XLEN-1:0]       q_data1,
   output logic [XLEN-1:0]       q_data2
`endif
);

   localparam int ST_W = $clog2(STARVE_MAX + 1);

   wb_req_t               wb_req;
   wb_req_t               wr_req;
   logic                  wb_grant;
   logic                  head_pop;
   logic                  push;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic [REG_ADDR_W-1:0] head_rd;
   logic [XLEN-1:0]       head_data;
   logic                  head_kill;
   logic                  run_q, run_d;
   logic [ST_W-1:0]       starve_q, starve_d;

`ifdef RF_FWD_EN
   logic [DEPTH-1:0]            ent_live;
   logic [DEPTH*REG_ADDR_W-1:0] ent_rd;
   logic [DEPTH*XLEN-1:0]       ent_data;
   logic [$clog2(DEPTH)-1:0]    head_ptr;
`endif

   rf_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_rd   (mdu_rd),
      .push_data (mdu_data),
      .pop       (head_pop),
      .kill_en   (wb_grant),
      .kill_rd   (wb_rd),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .head_rd   (head_rd),
      .head_data (head_data),
      .head_kill (head_kill)
`ifdef RF_FWD_EN
      ,
      .ent_live  (ent_live),
      .ent_rd    (ent_rd),
      .ent_data  (ent_data),
      .head_ptr  (head_ptr)
`endif
   );

   // Arbitration: pipeline slot first, otherwise the buffer head; rd==0 results are swallowed.
   always_comb begin
      wb_req.valid = wb_valid;
      wb_req.rd    = wb_rd;
      wb_req.data  = wb_data;

      wb_grant  = rst_n & wb_req.valid & rd_writable(wb_req.rd);
      head_pop  = ~wb_grant & ~fifo_empty;
      mdu_ready = run_q & ~fifo_full;
      push      = mdu_valid & mdu_ready & rd_writable(mdu_rd);

      wr_req = '0;
      if (wb_grant) begin
         wr_req = wb_req;
      end else if (head_pop && !head_kill) begin
         wr_req.valid = 1'b1;
         wr_req.rd    = head_rd;
         wr_req.data  = head_data;
      end

      rf_we    = wr_req.valid;
      rf_waddr = wr_req.rd;
      rf_wdata = wr_req.data;
   end

   // Starvation tracking: count cycles the buffered head loses to the pipeline.
   always_comb begin
      run_d = 1'b1;
      if (wb_grant && !fifo_empty) begin
         starve_d = (starve_q == ST_W'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
      end else begin
         starve_d = '0;
      end
      stall_req = (starve_q == ST_W'(STARVE_MAX));
   end

   // run_q keeps mdu_ready low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q    <= 1'b0;
         starve_q <= '0;
      end else begin
         run_q    <= run_d;
         starve_q <= starve_d;
      end
   end

`ifdef RF_FWD_EN
   // Forwarding: scan oldest to youngest so the youngest live match wins, then the current push.
   always_comb begin
      logic [$clog2(DEPTH)-1:0] idx;
      logic [REG_ADDR_W-1:0]    e_rd;
      q_hit1  = 1'b0;
      q_hit2  = 1'b0;
      q_data1 = '0;
      q_data2 = '0;
      idx     = head_ptr;
      e_rd    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx  = head_ptr + ($clog2(DEPTH))'(k);
         e_rd = ent_rd[int'(idx)*REG_ADDR_W +: REG_ADDR_W];
         if (ent_live[idx] && rd_writable(q_rs1) && (e_rd == q_rs1)) begin
            q_hit1  = 1'b1;
            q_data1 = ent_data[int'(idx)*XLEN +: XLEN];
         end
         if (ent_live[idx] && rd_writable(q_rs2) && (e_rd == q_rs2)) begin
            q_hit2  = 1'b1;
            q_data2 = ent_data[int'(idx)*XLEN +: XLEN];
         end
      end
      if (push && rd_writable(q_rs1) && (mdu_rd == q_rs1)) begin
         q_hit1  = 1'b1;
         q_data1 = mdu_data;
      end
      if (push && rd_writable(q_rs2) && (mdu_rd == q_rs2)) begin
         q_hit2  = 1'b1;
         q_data2 = mdu_data;
      end
   end
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Testbench for rf_wr_arbiter: directed vectors with hand-computed literal
// expectations, plus a queue-based reference model compared every cycle.
module tb_rf_wr_arbiter;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk;
   logic        rst_n;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stall_req;
`ifdef RF_FWD_EN
   logic [4:0]  q_rs1, q_rs2;
   logic        q_hit1, q_hit2;
   logic [31:0] q_data1, q_data2;
   assign q_rs1 = 5'd0;
   assign q_rs2 = 5'd0;
`endif

   int nChecks = 0;
   int nFails  = 0;

   rf_wr_arbiter #(
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .mdu_valid (mdu_valid),
      .mdu_rd    (mdu_rd),
      .mdu_data  (mdu_data),
      .mdu_ready (mdu_ready),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .stall_req (stall_req)
`ifdef RF_FWD_EN
      ,
      .q_rs1     (q_rs1),
      .q_rs2     (q_rs2),
      .q_hit1    (q_hit1),
      .q_hit2    (q_hit2),
      .q_data1   (q_data1),
      .q_data2   (q_data2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its required value and count the outcome.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle's worth of inputs.
   task automatic applyStimulus(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] md);
      wb_valid  = wv;
      wb_rd     = wrd;
      wb_data   = wd;
      mdu_valid = mv;
      mdu_rd    = mrd;
      mdu_data  = md;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: pending results in arrival order, with a killed flag each.
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          killed;
   } ent_t;

   ent_t mq[$];
   int   starve = 0;
   bit   running = 0;

   // Model update at each clock edge from the inputs presented during the cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         starve  = 0;
         running = 0;
      end else begin
         bit ready, grant, nonempty;
         ready    = running && (mq.size() < DEPTH);
         grant    = wb_valid && (wb_rd != 5'd0);
         nonempty = (mq.size() > 0);
         if (grant) begin
            foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].killed = 1;
         end else if (nonempty) begin
            void'(mq.pop_front());
         end
         if (grant && nonempty) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
         else starve = 0;
         if (mdu_valid && ready && (mdu_rd != 5'd0)) begin
            ent_t e;
            e.rd = mdu_rd;
            e.data = mdu_data;
            e.killed = 0;
            mq.push_back(e);
         end
         running = 1;
      end
   end

   // Every-cycle comparison of all outputs against the model, mid-cycle.
   always @(negedge clk) begin
      logic        eWe, eReady, eStall;
      logic [4:0]  eAddr;
      logic [31:0] eData;
      eWe = 0; eAddr = 0; eData = 0;
      eReady = running && (mq.size() < DEPTH);
      eStall = (starve == STARVE_MAX);
      if (rst_n && wb_valid && wb_rd != 5'd0) begin
         eWe = 1; eAddr = wb_rd; eData = wb_data;
      end else if (mq.size() > 0 && !mq[0].killed) begin
         eWe = 1; eAddr = mq[0].rd; eData = mq[0].data;
      end
      checkOutput("model_rf_we", {31'd0, rf_we}, {31'd0, eWe});
      checkOutput("model_rf_waddr", {27'd0, rf_waddr}, {27'd0, eAddr});
      checkOutput("model_rf_wdata", rf_wdata, eData);
      checkOutput("model_mdu_ready", {31'd0, mdu_ready}, {31'd0, eReady});
      checkOutput("model_stall_req", {31'd0, stall_req}, {31'd0, eStall});
   end

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("reset_rf_we", {31'd0, rf_we}, 32'd0);
      checkOutput("reset_mdu_ready", {31'd0, mdu_ready}, 32'd0);
      checkOutput("reset_stall_req", {31'd0, stall_req}, 32'd0);
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ready_before_edge", {31'd0, mdu_ready}, 32'd0);
      cyc();
      @(negedge clk);
      checkOutput("ready_after_release", {31'd0, mdu_ready}, 32'd1);
      cyc();

      $display("[TB] pipeline write with empty buffer");
      applyStimulus(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      checkOutput("wb_we", {31'd0, rf_we}, 32'd1);
      checkOutput("wb_addr", {27'd0, rf_waddr}, 32'd5);
      checkOutput("wb_data", rf_wdata, 32'h11);
      cyc();

      $display("[TB] mdu result drains next cycle");
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAB);
      @(negedge clk);
      checkOutput("mdu_push_no_we", {31'd0, rf_we}, 32'd0);
      cyc();
      idle();
      @(negedge clk);
      checkOutput("mdu_drain_we", {31'd0, rf_we}, 32'd1);
      checkOutput("mdu_drain_addr", {27'd0, rf_waddr}, 32'd7);
      checkOutput("mdu_drain_data", rf_wdata, 32'hAB);
      cyc();
      @(negedge clk);
      checkOutput("mdu_empty_after", {31'd0, rf_we}, 32'd0);
      cyc();

      $display("[TB] WAW kill");
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
      cyc();
      applyStimulus(1'b1, 5'd3, 32'h99, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      checkOutput("kill_wb_addr", {27'd0, rf_waddr}, 32'd3);
      checkOutput("kill_wb_data", rf_wdata, 32'h99);
      cyc();
      idle();
      @(negedge clk);
      checkOutput("killed_pop_we", {31'd0, rf_we}, 32'd0);
      cyc();
      @(negedge clk);
      checkOutput("killed_after_we", {31'd0, rf_we}, 32'd0);
      cyc();

      $display("[TB] push alongside matching pipeline write survives");
      applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h4A);
      @(negedge clk);
      checkOutput("newer_wb_data", rf_wdata, 32'h44);
      cyc();
      idle();
      @(negedge clk);
      checkOutput("newer_mdu_we", {31'd0, rf_we}, 32'd1);
      checkOutput("newer_mdu_data", rf_wdata, 32'h4A);
      cyc();

      $display("[TB] starvation stall");
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h909);
      cyc();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'(10 + i), 32'(i), 1'b0, 5'd0, 32'd0);
         @(negedge clk);
         checkOutput("starve_no_stall", {31'd0, stall_req}, 32'd0);
         cyc();
      end
      idle();
      @(negedge clk);
      checkOutput("starve_stall", {31'd0, stall_req}, 32'd1);
      checkOutput("starve_head_addr", {27'd0, rf_waddr}, 32'd9);
      checkOutput("starve_head_data", rf_wdata, 32'h909);
      cyc();
      @(negedge clk);
      checkOutput("starve_stall_clear", {31'd0, stall_req}, 32'd0);
      cyc();

      $display("[TB] fill under continuous pipeline grants");
      applyStimulus(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hC2);
      cyc();
      applyStimulus(1'b1, 5'd13, 32'hB3, 1'b1, 5'd14, 32'hC4);
      @(negedge clk);
      checkOutput("fill_ready_one", {31'd0, mdu_ready}, 32'd1);
      cyc();
      applyStimulus(1'b1, 5'd15, 32'hB5, 1'b1, 5'd16, 32'hC6);
      @(negedge clk);
      checkOutput("full_ready", {31'd0, mdu_ready}, 32'd0);
      cyc();
      idle();
      @(negedge clk);
      checkOutput("full_drain0_addr", {27'd0, rf_waddr}, 32'd12);
      cyc();
      @(negedge clk);
      checkOutput("full_drain1_addr", {27'd0, rf_waddr}, 32'd14);
      cyc();
      @(negedge clk);
      checkOutput("full_dropped_we", {31'd0, rf_we}, 32'd0);
      cyc();

      $display("[TB] x0 result is dropped");
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
      cyc();
      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("x0_no_we", {31'd0, rf_we}, 32'd0);
         cyc();
      end

      $display("[TB] push and pop in the same cycle keep order");
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'hA1);
      cyc();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hA2);
      @(negedge clk);
      checkOutput("order0_data", rf_wdata, 32'hA1);
      cyc();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hA3);
      @(negedge clk);
      checkOutput("order1_data", rf_wdata, 32'hA2);
      cyc();
      idle();
      @(negedge clk);
      checkOutput("order2_addr", {27'd0, rf_waddr}, 32'd6);
      cyc();

      $display("[TB] reset with buffered entries");
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hB0);
      cyc();
      applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd21, 32'hB1);
      cyc();
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midreset_we", {31'd0, rf_we}, 32'd0);
      checkOutput("midreset_ready", {31'd0, mdu_ready}, 32'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      @(negedge clk);
      checkOutput("postreset_ready", {31'd0, mdu_ready}, 32'd1);
      checkOutput("postreset_we", {31'd0, rf_we}, 32'd0);
      cyc();
      repeat (3) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, MDU result FIFO entries (power of two, 2..8).
REQ-002 Parameter STARVE_MAX, default 4, consecutive denied cycles before a pipeline stall is requested.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 wb_valid, wb_rd, wb_data  in  1/5/32  pipeline writeback slot; cannot be back-pressured.
REQ-006 mdu_valid, mdu_rd, mdu_data  in  1/5/32  multi-cycle unit result.
REQ-007 mdu_ready  out  1  FIFO can accept; transfer when mdu_valid and mdu_ready.
REQ-008 rf_we, rf_waddr, rf_wdata  out  1/5/32  single register-file write port.
REQ-009 stall_req  out  1  pipeline must hold its writeback slot empty.
REQ-010 q_rs1, q_rs2  in  5 each; q_hit1, q_hit2 out 1; q_data1, q_data2 out 32 (present only under RF_FWD_EN).

Function
REQ-011 Grant priority: pipeline slot first; FIFO head only when no pipeline write is granted.
REQ-012 Pipeline write granted when wb_valid and wb_rd != 0; rf_we/rf_waddr/rf_wdata then equal wb_* combinationally in the same cycle.
REQ-013 Otherwise, if FIFO non-empty, head drives rf_* same cycle and pops at posedge.
REQ-014 Writes to x0 are never issued: mdu entries with rd == 0 are accepted and dropped without occupying the FIFO.
REQ-015 rf_we = 0 whenever nothing is granted; rf_waddr/rf_wdata then 0.
REQ-016 mdu_ready = 1 when FIFO not full; push and pop in the same cycle on a full FIFO is not allowed (ready low when full).
REQ-017 Push and pop in the same cycle on a non-full FIFO: occupancy unchanged, order preserved; head-to-output latency of a pushed entry is one cycle minimum.
REQ-018 WAW kill: when a pipeline write to rd is granted, every valid FIFO entry with the same rd is marked killed; killed entries pop without asserting rf_we.
REQ-019 A push in the same cycle as a matching pipeline grant is not killed (MDU result is newer).
REQ-020 Starve counter increments each cycle FIFO non-empty and pipeline granted; clears on any FIFO pop or empty FIFO; saturates at STARVE_MAX.
REQ-021 stall_req = 1 while counter == STARVE_MAX, deasserts the cycle after the head pops.
REQ-022 Read/write pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.

Reset
REQ-023 rst_n low: FIFO empty, kill bits cleared, starve counter 0, rf_we 0, stall_req 0, mdu_ready 0.
REQ-024 mdu_ready rises the first cycle after rst_n deasserts; reset mid-operation discards all buffered entries without writing.

Configuration
REQ-025 RF_FWD_EN defined: q_hitN = 1 when the youngest non-killed FIFO entry (or the current push) has rd == q_rsN != 0, q_dataN its data, combinational; youngest wins.
REQ-026 RF_FWD_EN undefined: q_* ports absent, no comparators synthesized; function otherwise identical.

Structure
REQ-027 Shared package rf_pkg: REG_ADDR_W = 5, XLEN = 32, wb_req_t (valid, rd, data) typedef.
REQ-028 One sub-module rf_wb_fifo (storage, pointers, per-entry kill bits, rd match vector); arbitration, starvation and forwarding in top.

Verification
REQ-029 wb_valid=1 rd=5 data=0x11 with FIFO empty -> rf_we=1, rf_waddr=5, rf_wdata=0x11 same cycle.
REQ-030 mdu push rd=7 data=0xAB, wb_valid=0 -> next cycle rf_we=1 waddr=7 wdata=0xAB, FIFO empty after.
REQ-031 FIFO holds rd=3, pipeline writes rd=3 -> entry killed, later pops with rf_we=0; x3 keeps pipeline value.
REQ-032 FIFO non-empty, wb_valid=1 rd!=0 for 4 cycles -> stall_req=1 on 5th cycle; wb_valid=0 -> head writes, stall_req=0 next cycle.
REQ-033 Two pushes fill DEPTH=2 under continuous wb grants -> mdu_ready=0; mdu push rd=0 while empty -> no rf_we ever.
REQ-034 Reset asserted with 2 entries buffered -> no rf_we, mdu_ready=0; after release FIFO empty, mdu_ready=1.
